controlador_memoria: RTL and testbench

CONTROLADOR_MEMORIA -- requirements
Module: controlador_memoria

---
 rtl/controlador_memoria_if.sv | 27 ++
 rtl/controlador_memoria.sv | 109 ++++++++++
 tb/tb_controlador_memoria.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/controlador_memoria_if.sv
// Snooping-bus interface between the caches and the memory controller.
// Carries miss requests, write-backs and aborts in, and response/status signals out.
// No flow control of its own; the controller reports busy and rejected requests.
interface controlador_memoria_if #(
    parameter int LARGURA_DADO = 8
);
    logic                    req;
    logic [1:0]              mensagem;
    logic [2:0]              endereco;
    logic                    writeBack;
    logic [LARGURA_DADO-1:0] dadoWriteBack;
    logic                    abortAccessMemory;
    logic                    ocupado;
    logic [LARGURA_DADO-1:0] dadoSaida;
    logic                    dadoValido;
    logic                    rejeitado;

    modport master (
        output req, mensagem, endereco, writeBack, dadoWriteBack, abortAccessMemory,
        input  ocupado, dadoSaida, dadoValido, rejeitado
    );

    modport slave (
        input  req, mensagem, endereco, writeBack, dadoWriteBack, abortAccessMemory,
        output ocupado, dadoSaida, dadoValido, rejeitado
    );
endinterface

// File: rtl/controlador_memoria.sv
// Purpose: 8-word shared memory answering snooping-bus read/write misses, with write-backs.
// Latency: response strobe LATENCIA+1 cycles after the accepting edge; abort takes 1 busy cycle.
// Backpressure: none; misses arriving while busy are dropped and flagged by a rejeitado pulse.
module controlador_memoria #(
    parameter int LATENCIA     = 3,
    parameter int LARGURA_DADO = 8
) (
    input logic                  clock,
    input logic                  reset,
    controlador_memoria_if.slave bus
);

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        ACESSO   = 2'd1,
        RESPOSTA = 2'd2,
        ABORTO   = 2'd3
    } estado_t;

    localparam logic [3:0] CONTADOR_INICIAL = 4'(LATENCIA - 1);

    estado_t                 estado_q;
    logic [3:0]              contador_q;
    logic [2:0]              endereco_q;
    logic                    ocupado_q;
    logic                    valido_q;
    logic                    rejeitado_q;
    logic [LARGURA_DADO-1:0] mem_q [0:7];
    logic [LARGURA_DADO-1:0] dado_lido;
    logic                    pedido_miss;

    // Only read and write misses start a transaction; the other two codes are inert.
    assign pedido_miss = bus.req && ((bus.mensagem == 2'b01) || (bus.mensagem == 2'b10));

    // Transaction FSM with registered status outputs; abort is only looked at on acceptance.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q    <= OCIOSO;
            contador_q  <= '0;
            endereco_q  <= '0;
            ocupado_q   <= 1'b0;
            valido_q    <= 1'b0;
            rejeitado_q <= 1'b0;
        end else begin
            rejeitado_q <= pedido_miss && (estado_q != OCIOSO);
            case (estado_q)
                OCIOSO: begin
                    if (pedido_miss) begin
                        endereco_q <= bus.endereco;
                        ocupado_q  <= 1'b1;
                        if (bus.abortAccessMemory) begin
                            estado_q <= ABORTO;
                        end else begin
                            estado_q   <= ACESSO;
                            contador_q <= CONTADOR_INICIAL;
                        end
                    end
                end
                ACESSO: begin
                    if (contador_q == 4'd0) begin
                        estado_q <= RESPOSTA;
                        valido_q <= 1'b1;
                    end else begin
                        contador_q <= contador_q - 4'd1;
                    end
                end
                RESPOSTA: begin
                    estado_q  <= OCIOSO;
                    valido_q  <= 1'b0;
                    ocupado_q <= 1'b0;
                end
                ABORTO: begin
                    estado_q  <= OCIOSO;
                    ocupado_q <= 1'b0;
                end
                default: begin
                    estado_q  <= OCIOSO;
                    ocupado_q <= 1'b0;
                    valido_q  <= 1'b0;
                end
            endcase
        end
    end

    // Memory array: write-backs land in any state; reset wipes every word first.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                mem_q[i] <= '0;
            end
        end else if (bus.writeBack) begin
            mem_q[bus.endereco] <= bus.dadoWriteBack;
        end
    end

    // Read of the pending word, forwarding a same-cycle write-back so the response is never stale.
    always_comb begin
        dado_lido = mem_q[endereco_q];
        if (bus.writeBack && (bus.endereco == endereco_q)) begin
            dado_lido = bus.dadoWriteBack;
        end
    end

    assign bus.ocupado    = ocupado_q;
    assign bus.dadoValido = valido_q;
    assign bus.rejeitado  = rejeitado_q;
    assign bus.dadoSaida  = valido_q ? dado_lido : '0;

endmodule

// File: tb/tb_controlador_memoria.sv
// Bench for controlador_memoria: directed scenarios followed by random bus traffic.
// Expected behaviour comes from a busy-interval / memory-array model fed by the driver.
// A negedge monitor compares status every cycle and pops responses from a scoreboard queue.
module tb_controlador_memoria;

    localparam int L = 3;
    localparam int W = 8;

    logic clock;
    logic reset;

    controlador_memoria_if #(.LARGURA_DADO(W)) bus_if ();

    controlador_memoria #(.LATENCIA(L), .LARGURA_DADO(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        int         cyc;
        logic [2:0] addr;
    } resp_t;

    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    bit         chk_en = 0;
    bit         reset_seen = 0;
    int         busy_lo = 0;
    int         busy_hi = -1;
    logic [W-1:0] model_mem [0:7];
    resp_t      resp_q [$];
    int         rej_q [$];

    logic exp_occ, exp_rej, exp_v;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // One bus cycle: apply inputs just after the edge, then let the model absorb them.
    task automatic drive(input logic rst, input logic rq, input logic [1:0] msg,
                         input logic [2:0] a, input logic wb, input logic [W-1:0] wd,
                         input logic ab);
        @(posedge clock);
        #1;
        reset                    = rst;
        bus_if.req               = rq;
        bus_if.mensagem          = msg;
        bus_if.endereco          = a;
        bus_if.writeBack         = wb;
        bus_if.dadoWriteBack     = wd;
        bus_if.abortAccessMemory = ab;
        if (reset_seen) chk_en = 1;
        if (rst) begin
            reset_seen = 1;
            for (int i = 0; i < 8; i++) model_mem[i] = '0;
            while (resp_q.size() > 0 && resp_q[resp_q.size()-1].cyc > cyc)
                void'(resp_q.pop_back());
            if (busy_hi > cyc) busy_hi = cyc;
        end else begin
            // model_mem holds the contents as they stand at the end of this cycle,
            // which is also what a write-first response in this cycle must show.
            if (wb) model_mem[a] = wd;
            if (rq && (msg == 2'b01 || msg == 2'b10)) begin
                if (cyc > busy_hi) begin
                    busy_lo = cyc + 1;
                    if (ab) begin
                        busy_hi = cyc + 1;
                    end else begin
                        busy_hi = cyc + L + 1;
                        resp_q.push_back('{cyc: cyc + L + 1, addr: a});
                    end
                end else begin
                    rej_q.push_back(cyc + 1);
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 2'b11, 3'd0, 1'b0, '0, 1'b0);
    endtask

    task automatic miss(input logic [1:0] msg, input logic [2:0] a);
        drive(1'b0, 1'b1, msg, a, 1'b0, '0, 1'b0);
    endtask

    // Monitor: status every cycle, responses popped from the scoreboard.
    always @(negedge clock) begin
        if (chk_en) begin
            exp_occ = (cyc >= busy_lo) && (cyc <= busy_hi);
            chk("ocupado", 32'(bus_if.ocupado), 32'(exp_occ));

            while (rej_q.size() > 0 && rej_q[0] < cyc) void'(rej_q.pop_front());
            exp_rej = (rej_q.size() > 0) && (rej_q[0] == cyc);
            if (exp_rej) void'(rej_q.pop_front());
            chk("rejeitado", 32'(bus_if.rejeitado), 32'(exp_rej));

            while (resp_q.size() > 0 && resp_q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL resp_missing cycle %0d: no strobe seen, required one at cycle %0d",
                         cyc, resp_q[0].cyc);
                void'(resp_q.pop_front());
            end
            exp_v = (resp_q.size() > 0) && (resp_q[0].cyc == cyc);
            chk("dadoValido", 32'(bus_if.dadoValido), 32'(exp_v));
            if (exp_v) begin
                chk("dadoSaida", 32'(bus_if.dadoSaida), 32'(model_mem[resp_q[0].addr]));
                void'(resp_q.pop_front());
            end else begin
                chk("dadoSaida_zero", 32'(bus_if.dadoSaida), 32'd0);
            end
        end
    end

    initial begin
        logic          r_rst, r_req, r_wb, r_ab;
        logic [1:0]    r_msg;
        logic [2:0]    r_a;
        logic [W-1:0]  r_wd;

        reset                    = 1'b1;
        bus_if.req               = 1'b0;
        bus_if.mensagem          = 2'b11;
        bus_if.endereco          = '0;
        bus_if.writeBack         = 1'b0;
        bus_if.dadoWriteBack     = '0;
        bus_if.abortAccessMemory = 1'b0;
        for (int i = 0; i < 8; i++) model_mem[i] = '0;

        drive(1'b1, 1'b0, 2'b11, 3'd0, 1'b0, '0, 1'b0);
        drive(1'b1, 1'b1, 2'b01, 3'd0, 1'b1, 8'hFF, 1'b0);
        idle(2);

        // Write-back then read of the same block.
        drive(1'b0, 1'b0, 2'b11, 3'd5, 1'b1, 8'hA7, 1'b0);
        miss(2'b01, 3'd5);
        idle(5);

        // Aborted write miss with a simultaneous write-back, then read it back.
        drive(1'b0, 1'b1, 2'b10, 3'd2, 1'b1, 8'h3C, 1'b1);
        idle(2);
        miss(2'b01, 3'd2);
        idle(5);

        // Back-to-back misses: second one is dropped.
        miss(2'b01, 3'd3);
        miss(2'b01, 3'd4);
        idle(5);

        // Write-back during ACESSO and during RESPOSTA to the pending block.
        miss(2'b10, 3'd1);
        idle(1);
        drive(1'b0, 1'b0, 2'b11, 3'd1, 1'b1, 8'h55, 1'b0);
        idle(4);
        miss(2'b01, 3'd6);
        idle(3);
        drive(1'b0, 1'b0, 2'b11, 3'd6, 1'b1, 8'h99, 1'b0);
        idle(3);

        // Miss in RESPOSTA is rejected, the next cycle is accepted.
        miss(2'b01, 3'd0);
        idle(3);
        miss(2'b01, 3'd5);
        miss(2'b10, 3'd5);
        idle(6);

        // Reset in the middle of ACESSO, then memory reads back as zero.
        drive(1'b0, 1'b0, 2'b11, 3'd7, 1'b1, 8'h11, 1'b0);
        miss(2'b01, 3'd7);
        idle(1);
        drive(1'b1, 1'b0, 2'b11, 3'd7, 1'b1, 8'h22, 1'b0);
        idle(1);
        miss(2'b01, 3'd7);
        idle(5);
        miss(2'b01, 3'd5);
        idle(5);

        // Non-miss messages do nothing, whether idle or busy.
        miss(2'b00, 3'd4);
        miss(2'b11, 3'd4);
        idle(2);
        miss(2'b01, 3'd0);
        miss(2'b11, 3'd1);
        miss(2'b00, 3'd1);
        idle(5);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            r_rst = ($urandom_range(99) == 0);
            if (r_rst && resp_q.size() > 0 && resp_q[0].cyc == cyc + 1) r_rst = 1'b0;
            r_req = ($urandom_range(1) == 1);
            r_msg = 2'($urandom_range(3));
            r_a   = 3'($urandom_range(7));
            r_wb  = ($urandom_range(9) < 3);
            r_wd  = W'($urandom_range(255));
            r_ab  = ($urandom_range(4) == 0);
            drive(r_rst, r_req, r_msg, r_a, r_wb, r_wd, r_ab);
        end

        idle(L + 5);
        @(negedge clock);
        #1;
        checks++;
        if (resp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses outstanding, required 0", resp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
